// File: rtl/ci_pkg.sv
// Shared definitions for custom-instruction (CI) wrappers: FSM state type,
// default widths and the wait-counter sizing helper.
package ci_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ci_state_t;

  localparam int CI_DATAA_W  = 32;
  localparam int CI_DATAB_W  = 32;
  localparam int CI_RESULT_W = 32;
  localparam int CI_TIMEOUT  = 64;

  // Counter must hold 0..TIMEOUT-1; never narrower than one bit.
  function automatic int ci_cnt_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ci_initiator_if.sv
// Request stream, response stream and CI slave bus of one CI initiator.
// Streams are strict valid/ready: a beat transfers on a cycle with both high;
// valid never drops and payload never changes until that transfer happens.
interface ci_initiator_if #(
  parameter int DATAA_W  = 32,
  parameter int DATAB_W  = 32,
  parameter int RESULT_W = 32
);

  logic                req_valid;
  logic                req_ready;
  logic [DATAA_W-1:0]  req_dataa;
  logic [DATAB_W-1:0]  req_datab;
  logic                req_datac;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [RESULT_W-1:0] rsp_result;
  logic                rsp_timeout;

  logic                ci_clk_en;
  logic                ci_start;
  logic [DATAA_W-1:0]  ci_dataa;
  logic [DATAB_W-1:0]  ci_datab;
  logic                ci_datac;
  logic [RESULT_W-1:0] ci_result;
  logic                ci_done;

  modport master (
    input  req_valid, req_dataa, req_datab, req_datac,
    output req_ready,
    output rsp_valid, rsp_result, rsp_timeout,
    input  rsp_ready,
    output ci_clk_en, ci_start, ci_dataa, ci_datab, ci_datac,
    input  ci_result, ci_done
  );

  modport slave (
    output req_valid, req_dataa, req_datab, req_datac,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_timeout,
    output rsp_ready,
    input  ci_clk_en, ci_start, ci_dataa, ci_datab, ci_datac,
    output ci_result, ci_done
  );

endinterface

// File: rtl/ci_initiator.sv
// Fabric-side initiator for a multi-cycle Nios II custom instruction: issues one
// request to the CI slave, waits for done (or a timeout) and returns the result.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int DATAA_W  = CI_DATAA_W,
  parameter int DATAB_W  = CI_DATAB_W,
  parameter int RESULT_W = CI_RESULT_W,
  parameter int TIMEOUT  = CI_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  ci_initiator_if.master bus,
  output logic          busy,
  output logic [15:0]   txn_count,
  output logic [15:0]   timeout_count,
  output ci_state_t     state
);

  localparam int CNT_W = ci_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  ci_state_t        state_q;
  logic [CNT_W-1:0] wait_cnt;

  assign state         = state_q;
  assign busy          = (state_q != IDLE);
  assign bus.req_ready = (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      wait_cnt        <= '0;
      bus.ci_start    <= 1'b0;
      bus.ci_clk_en   <= 1'b0;
      bus.ci_dataa    <= '0;
      bus.ci_datab    <= '0;
      bus.ci_datac    <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_result  <= '0;
      bus.rsp_timeout <= 1'b0;
      txn_count       <= '0;
      timeout_count   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            bus.ci_dataa  <= bus.req_dataa;
            bus.ci_datab  <= bus.req_datab;
            bus.ci_datac  <= bus.req_datac;
            bus.ci_start  <= 1'b1;
            bus.ci_clk_en <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        // ci_done is not looked at here: the slave may still show last call's done.
        ISSUE: begin
          bus.ci_start <= 1'b0;
          wait_cnt     <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (bus.ci_done) begin
            bus.rsp_result  <= bus.ci_result;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.ci_clk_en   <= 1'b0;
            state_q         <= RESP;
          end else if ((TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
            bus.rsp_result  <= '0;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.ci_clk_en   <= 1'b0;
            state_q         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state_q       <= IDLE;
            if (txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
            if (bus.rsp_timeout && (timeout_count != 16'hFFFF))
              timeout_count <= timeout_count + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ci_initiator.sv
// Randomized bench for ci_initiator with a latency-programmable CI slave model
// and a transaction-level scoreboard of expected responses and latencies.
module tb_ci_initiator;
  import ci_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [15:0] txn_count, timeout_count;
  ci_state_t   dbg_state;

  ci_initiator_if #(.DATAA_W(32), .DATAB_W(32), .RESULT_W(32)) bus ();

  ci_initiator #(.DATAA_W(32), .DATAB_W(32), .RESULT_W(32), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .busy          (busy),
    .txn_count     (txn_count),
    .timeout_count (timeout_count),
    .state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_fn(input logic [31:0] a, input logic [31:0] b, input logic c);
    return c ? (a - b) : (a + (b << 1));
  endfunction

  // ---------------- CI slave model ----------------
  int          slv_lat = 1;     // 0 means the slave never completes
  int          slv_lat_act = 0;
  int          slv_cnt = 0;
  logic        slv_active = 1'b0;
  logic        spur_done = 1'b0;
  logic [31:0] garbage = 32'h0;
  logic        slv_done;

  always @(posedge clk) begin
    garbage <= $urandom;
    if (reset || !bus.ci_clk_en) begin
      slv_active <= 1'b0;
      slv_cnt    <= 0;
    end else if (bus.ci_start) begin
      slv_active  <= 1'b1;
      slv_cnt     <= 1;
      slv_lat_act <= slv_lat;
    end else if (slv_active) begin
      slv_cnt <= slv_cnt + 1;
    end
  end

  assign slv_done      = slv_active && (slv_lat_act != 0) && (slv_cnt == slv_lat_act);
  assign bus.ci_done   = slv_done || spur_done;
  assign bus.ci_result = slv_done ? ref_fn(bus.ci_dataa, bus.ci_datab, bus.ci_datac) : garbage;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];      // {timeout, result}
  int          exp_lat_q[$];  // accept cycle -> first rsp_valid cycle
  int          acc_cyc = 0;
  logic [64:0] cur_ops = '0;  // {c, b, a} of the outstanding request
  int          m_txn = 0;
  int          m_to = 0;
  int          start_cnt = 0;

  // ---------------- response-side drivers ----------------
  logic bp_low = 1'b0;
  logic rdy_rand = 1'b0;

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = bp_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (bus.ci_start) begin
          start_cnt++;
          check("start_cycle", 64'(cyc), 64'(acc_cyc + 1));
          check("ci_operands", {bus.ci_datac, bus.ci_datab, bus.ci_dataa}, cur_ops[63:0]);
          check("ci_datac", bus.ci_datac, cur_ops[64]);
        end
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            if (!prev_valid) check("rsp_latency", 64'(cyc - acc_cyc), 64'(exp_lat_q[0]));
            check("rsp_payload", {bus.rsp_timeout, bus.rsp_result}, exp_q[0]);
            check("req_ready_in_rsp", bus.req_ready, 0);
            if (bus.rsp_ready) begin
              if (exp_q[0][32]) m_to++;
              m_txn++;
              void'(exp_q.pop_front());
              void'(exp_lat_q.pop_front());
            end
          end
        end
        prev_valid = bus.rsp_valid && !bus.rsp_ready;
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input int lat, input logic spur);
    int n;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_dataa = a;
    bus.req_datab = b;
    bus.req_datac = c;
    slv_lat = lat;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 200) begin
        check("req_accept_timeout", 1, 0);
        break;
      end
    end
    acc_cyc = cyc;
    cur_ops = {c, b, a};
    if (lat == 0 || lat > TO) begin
      exp_q.push_back({1'b1, 32'h0});
      exp_lat_q.push_back(TO + 2);
    end else begin
      exp_q.push_back({1'b0, ref_fn(a, b, c)});
      exp_lat_q.push_back(lat + 2);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_dataa = $urandom;
    bus.req_datab = $urandom;
    bus.req_datac = 1'($urandom_range(0, 1));
    spur_done = spur;
    if (spur) begin
      @(posedge clk);
      #1;
      spur_done = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_txn"}, txn_count, 64'(m_txn));
    check({tag, "_to"}, timeout_count, 64'(m_to));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_lat_q.delete();
    m_txn = 0;
    m_to  = 0;
    #1;
    reset = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s0, t0;
    bus.req_valid = 1'b0;
    bus.req_dataa = '0;
    bus.req_datab = '0;
    bus.req_datac = 1'b0;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_ci_start", bus.ci_start, 0);
    check("rst_ci_clk_en", bus.ci_clk_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp", {bus.rsp_timeout, bus.rsp_result}, 0);
    check("rst_ci_data", {bus.ci_datac, bus.ci_datab, bus.ci_dataa}, 0);
    check_counters("rst");

    // latency-3 slave, dataa=5, datab=2
    send_req(32'h5, 32'h2, 1'b0, 3, 1'b0);
    drain();
    check_counters("lat3");

    // backpressure: response held for 10 cycles
    bp_low = 1'b1;
    send_req($urandom, $urandom, 1'b1, 3, 1'b0);
    begin
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("bp_rsp_seen", bus.rsp_valid, 1);
      t0 = m_txn;
      repeat (10) begin
        @(negedge clk);
        check("bp_txn_hold", txn_count, 64'(t0));
      end
    end
    bp_low = 1'b0;
    drain();
    check_counters("bp");

    // timeout: slave never completes
    send_req($urandom, $urandom, 1'b0, 0, 1'b0);
    drain();
    check("to_count_one", timeout_count, 1);
    check_counters("to");

    // spurious done in IDLE, then during ISSUE with real done at latency 2
    @(posedge clk);
    #1;
    spur_done = 1'b1;
    @(posedge clk);
    #1;
    spur_done = 1'b0;
    @(negedge clk);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_rsp", bus.rsp_valid, 0);
    send_req($urandom, $urandom, 1'b1, 2, 1'b1);
    drain();
    check_counters("spur");

    // reset in the middle of WAIT
    send_req($urandom, $urandom, 1'b0, 20, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstw_clk_en", bus.ci_clk_en, 0);
    check("rstw_rsp_valid", bus.rsp_valid, 0);
    check("rstw_busy", busy, 0);
    exp_q.delete();
    exp_lat_q.delete();
    m_txn = 0;
    m_to  = 0;
    check_counters("rstw");
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_req($urandom, $urandom, 1'b0, 4, 1'b0);
    drain();
    check_counters("post_rst");

    // back-to-back
    s0 = start_cnt;
    t0 = m_txn;
    for (int i = 0; i < 5; i++)
      send_req($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 4), 1'b0);
    drain();
    check("b2b_starts", 64'(start_cnt - s0), 5);
    check("b2b_txn", txn_count, 64'(t0 + 5));

    // randomized traffic with random backpressure and occasional timeouts
    rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_req($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 11), 1'b0);
    end
    drain();
    rdy_rand = 1'b0;
    drain();
    check_counters("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "simulation time limit");
  end

endmodule
